// File: rtl/system_sysid_checker_if.sv
// ---------------------------------------------------------------------------
// system_sysid_checker_if
// Avalon-MM read-only link between the system ID checker (master) and the
// system ID slave (control_slave).
//   avm_address      master -> slave   word address (0 = id, 1 = timestamp)
//   avm_read         master -> slave   read strobe
//   avm_waitrequest  slave  -> master  stall, read accepted when low
//   avm_readdata     slave  -> master  32-bit read data
// ---------------------------------------------------------------------------
interface system_sysid_checker_if;
    logic        avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;

    modport master (
        output avm_address,
        output avm_read,
        input  avm_waitrequest,
        input  avm_readdata
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        output avm_waitrequest,
        output avm_readdata
    );
endinterface

// File: rtl/system_sysid_checker.sv
// ---------------------------------------------------------------------------
// system_sysid_checker
// Reads the system ID word (address 0) and the build timestamp word
// (address 1) from the sysid slave, compares both against the expected
// values and publishes sticky pass/fail results.  A check runs after reset
// (AUTO_START), on a start pulse, or periodically (RECHECK_PERIOD > 0).
//
// Ports
//   clock      system clock, rising edge
//   reset_n    asynchronous active-low reset
//   start      pulse, requests a check; ignored while a check is running
//   avm        Avalon-MM master side (address, read, waitrequest, readdata)
//   busy       check in progress (low only in IDLE)
//   done       one-cycle pulse when the result registers update
//   id_ok      last id word matched EXPECTED_ID
//   ts_ok      last timestamp word matched EXPECTED_TIMESTAMP
//   match      id_ok & ts_ok & ~timeout
//   timeout    last check aborted on a waitrequest timeout
//   id_value   last captured id word
//   ts_value   last captured timestamp word
// ---------------------------------------------------------------------------
module system_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID        = 32'd0,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1392326789,
    parameter int          READ_LATENCY       = 0,
    parameter int          TIMEOUT_CYCLES     = 255,
    parameter int          RECHECK_PERIOD     = 0,
    parameter bit          AUTO_START         = 1'b1
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          start,
    system_sysid_checker_if.master        avm,
    output logic                          busy,
    output logic                          done,
    output logic                          id_ok,
    output logic                          ts_ok,
    output logic                          match,
    output logic                          timeout,
    output logic [31:0]                   id_value,
    output logic [31:0]                   ts_value
);

    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RC_W   = (RECHECK_PERIOD > 1) ? $clog2(RECHECK_PERIOD) : 1;

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [RC_W-1:0]   RC_LAST   = (RECHECK_PERIOD > 0) ? RC_W'(RECHECK_PERIOD - 1) : '0;
    localparam logic [1:0]        LAT_LAST  = 2'(READ_LATENCY);

    typedef enum logic [2:0] {
        IDLE,
        REQ_ID,
        LAT_ID,
        REQ_TS,
        LAT_TS,
        FIN
    } state_t;

    state_t            state;
    logic              trig_q;
    logic              first_q;
    logic              run_to;
    logic [WAIT_W-1:0] wait_cnt;
    logic [1:0]        lat_cnt;
    logic [RC_W-1:0]   rc_cnt;
    logic [31:0]       id_shadow;
    logic [31:0]       ts_shadow;
    logic              recheck_hit;
    logic              launch;

    assign recheck_hit = (RECHECK_PERIOD > 0) && (rc_cnt == RC_LAST);

    // All trigger sources merge into a single registered request, so
    // coincident triggers can only ever launch one check.
    assign launch = start || recheck_hit || (AUTO_START && first_q);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            trig_q          <= 1'b0;
            first_q         <= 1'b1;
            run_to          <= 1'b0;
            wait_cnt        <= '0;
            lat_cnt         <= '0;
            rc_cnt          <= '0;
            id_shadow       <= '0;
            ts_shadow       <= '0;
            avm.avm_read    <= 1'b0;
            avm.avm_address <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            id_ok           <= 1'b0;
            ts_ok           <= 1'b0;
            match           <= 1'b0;
            timeout         <= 1'b0;
            id_value        <= '0;
            ts_value        <= '0;
        end else begin
            done    <= 1'b0;
            first_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (trig_q) begin
                        trig_q          <= 1'b0;
                        rc_cnt          <= '0;
                        run_to          <= 1'b0;
                        wait_cnt        <= '0;
                        busy            <= 1'b1;
                        avm.avm_read    <= 1'b1;
                        avm.avm_address <= 1'b0;
                        state           <= REQ_ID;
                    end else begin
                        trig_q <= launch;
                        // Idle counting starts after the done cycle, so done
                        // pulses are spaced RECHECK_PERIOD plus one check apart.
                        if (done || recheck_hit) begin
                            rc_cnt <= '0;
                        end else if (RECHECK_PERIOD > 0) begin
                            rc_cnt <= rc_cnt + 1'b1;
                        end
                    end
                end
                REQ_ID, REQ_TS: begin
                    if (!avm.avm_waitrequest) begin
                        if (READ_LATENCY == 0) begin
                            wait_cnt <= '0;
                            if (state == REQ_ID) begin
                                id_shadow       <= avm.avm_readdata;
                                avm.avm_address <= 1'b1;
                                state           <= REQ_TS;
                            end else begin
                                ts_shadow       <= avm.avm_readdata;
                                avm.avm_read    <= 1'b0;
                                avm.avm_address <= 1'b0;
                                state           <= FIN;
                            end
                        end else begin
                            avm.avm_read <= 1'b0;
                            lat_cnt      <= 2'd1;
                            state        <= (state == REQ_ID) ? LAT_ID : LAT_TS;
                        end
                    end else if (wait_cnt == WAIT_LAST) begin
                        // Slave stalled too long: abandon the whole check.
                        run_to          <= 1'b1;
                        avm.avm_read    <= 1'b0;
                        avm.avm_address <= 1'b0;
                        state           <= FIN;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                LAT_ID: begin
                    if (lat_cnt == LAT_LAST) begin
                        id_shadow       <= avm.avm_readdata;
                        wait_cnt        <= '0;
                        avm.avm_read    <= 1'b1;
                        avm.avm_address <= 1'b1;
                        state           <= REQ_TS;
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                LAT_TS: begin
                    if (lat_cnt == LAT_LAST) begin
                        ts_shadow       <= avm.avm_readdata;
                        avm.avm_address <= 1'b0;
                        state           <= FIN;
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                FIN: begin
                    // Published results change only here; a timed-out run
                    // keeps the previously captured words.
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    timeout <= run_to;
                    state   <= IDLE;
                    if (run_to) begin
                        id_ok <= 1'b0;
                        ts_ok <= 1'b0;
                        match <= 1'b0;
                    end else begin
                        id_value <= id_shadow;
                        ts_value <= ts_shadow;
                        id_ok    <= (id_shadow == EXPECTED_ID);
                        ts_ok    <= (ts_shadow == EXPECTED_TIMESTAMP);
                        match    <= (id_shadow == EXPECTED_ID) && (ts_shadow == EXPECTED_TIMESTAMP);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_system_sysid_checker.sv
// ---------------------------------------------------------------------------
// tb_system_sysid_checker
// Three checker instances share clock and reset:
//   dut_a  defaults, slave with programmable wait states and timestamp word
//   dut_b  TIMEOUT_CYCLES=16, RECHECK_PERIOD=100, slave with stuck waitrequest
//   dut_c  READ_LATENCY=2, AUTO_START=0, EXPECTED_ID=0xCAFE0001, pipelined slave
// ---------------------------------------------------------------------------
module tb_system_sysid_checker;

    localparam logic [31:0] TS   = 32'd1392326789;
    localparam logic [31:0] ID_C = 32'hCAFE0001;

    logic clock   = 1'b0;
    logic reset_n = 1'b1;
    logic start_a = 1'b0;
    logic start_b = 1'b0;
    logic start_c = 1'b0;

    int checks;
    int failures;

    system_sysid_checker_if ifa ();
    system_sysid_checker_if ifb ();
    system_sysid_checker_if ifc ();

    logic busy_a, done_a, id_ok_a, ts_ok_a, match_a, timeout_a;
    logic busy_b, done_b, id_ok_b, ts_ok_b, match_b, timeout_b;
    logic busy_c, done_c, id_ok_c, ts_ok_c, match_c, timeout_c;
    logic [31:0] id_value_a, ts_value_a, id_value_b, ts_value_b, id_value_c, ts_value_c;

    always #5 clock = ~clock;

    // Slave A: stock sysid contents with configurable timestamp and stalls.
    logic [31:0] ts_word_a = TS;
    int wait_per_read_a = 0;
    int stall_cnt_a = 0;
    assign ifa.avm_waitrequest = ifa.avm_read && (stall_cnt_a < wait_per_read_a);
    assign ifa.avm_readdata    = ifa.avm_address ? ts_word_a : 32'd0;
    always @(posedge clock) stall_cnt_a <= (ifa.avm_read && ifa.avm_waitrequest) ? stall_cnt_a + 1 : 0;

    // Slave B: stock contents, waitrequest can be held high.
    logic stuck_b = 1'b0;
    assign ifb.avm_waitrequest = ifb.avm_read && stuck_b;
    assign ifb.avm_readdata    = ifb.avm_address ? TS : 32'd0;

    // Slave C: data valid two cycles after accept, garbage otherwise.
    logic [31:0] pipe0_c, pipe1_c;
    always @(posedge clock) begin
        pipe0_c <= (ifc.avm_read && !ifc.avm_waitrequest) ? (ifc.avm_address ? TS : ID_C) : 32'hDEADBEEF;
        pipe1_c <= pipe0_c;
    end
    assign ifc.avm_waitrequest = 1'b0;
    assign ifc.avm_readdata    = pipe1_c;

    system_sysid_checker dut_a (
        .clock(clock), .reset_n(reset_n), .start(start_a), .avm(ifa),
        .busy(busy_a), .done(done_a), .id_ok(id_ok_a), .ts_ok(ts_ok_a), .match(match_a),
        .timeout(timeout_a), .id_value(id_value_a), .ts_value(ts_value_a)
    );

    system_sysid_checker #(.TIMEOUT_CYCLES(16), .RECHECK_PERIOD(100)) dut_b (
        .clock(clock), .reset_n(reset_n), .start(start_b), .avm(ifb),
        .busy(busy_b), .done(done_b), .id_ok(id_ok_b), .ts_ok(ts_ok_b), .match(match_b),
        .timeout(timeout_b), .id_value(id_value_b), .ts_value(ts_value_b)
    );

    system_sysid_checker #(.EXPECTED_ID(ID_C), .READ_LATENCY(2), .AUTO_START(1'b0)) dut_c (
        .clock(clock), .reset_n(reset_n), .start(start_c), .avm(ifc),
        .busy(busy_c), .done(done_c), .id_ok(id_ok_c), .ts_ok(ts_ok_c), .match(match_c),
        .timeout(timeout_c), .id_value(id_value_c), .ts_value(ts_value_c)
    );

    // Pulses start_a for one cycle and counts edges until done, sampling #1 after each edge.
    task automatic run_a(input int extra_at, output int n, output int idc, output int tsc,
                         output logic [31:0] mid_ts);
        @(posedge clock); #1 start_a = 1'b1;
        n = 0; idc = 0; tsc = 0; mid_ts = '0;
        do begin
            @(posedge clock); #1 n++;
            start_a = (n == extra_at);
            if (ifa.avm_read && !ifa.avm_address) idc++;
            if (ifa.avm_read && ifa.avm_address) tsc++;
            if (n == 3) mid_ts = ts_value_a;
        end while (!done_a && n < 300);
        start_a = 1'b0;
    endtask

    task automatic count_done_a(input int cycles, output int pulses);
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clock); #1 if (done_a) pulses++;
        end
    endtask

    task automatic run_b(output int n, output int rd);
        @(posedge clock); #1 start_b = 1'b1;
        n = 0; rd = 0;
        do begin
            @(posedge clock); #1 start_b = 1'b0; n++;
            if (ifb.avm_read) rd++;
        end while (!done_b && n < 300);
    endtask

    task automatic wait_done_b(output int n);
        n = 0;
        do begin
            @(posedge clock); #1 n++;
        end while (!done_b && n < 300);
    endtask

    task automatic test_reset;
        #2 reset_n = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if ({busy_a, done_a, id_ok_a, ts_ok_a, match_a, timeout_a, ifa.avm_read, ifa.avm_address,
             id_value_a, ts_value_a} !== 72'd0) begin
            failures++; $display("[TB] FAIL reset_a: outputs not all zero");
        end
        checks++;
        if ({busy_b, done_b, match_b, timeout_b, ifb.avm_read} !== 5'd0) begin
            failures++; $display("[TB] FAIL reset_b: got %b expected 00000", {busy_b, done_b, match_b, timeout_b, ifb.avm_read});
        end
        checks++;
        if ({busy_c, done_c, match_c, ifc.avm_read, id_value_c} !== 36'd0) begin
            failures++; $display("[TB] FAIL reset_c: outputs not all zero");
        end
    endtask

    task automatic test_auto_start;
        int n;
        @(negedge clock) reset_n = 1'b1;
        n = 0;
        do begin
            @(posedge clock); #1 n++;
        end while (!done_a && n < 300);
        checks++;
        if (n !== 5) begin failures++; $display("[TB] FAIL auto_latency: got %0d expected 5", n); end
        checks++;
        if (id_value_a !== 32'd0) begin failures++; $display("[TB] FAIL auto_id: got %0h expected 0", id_value_a); end
        checks++;
        if (ts_value_a !== TS) begin failures++; $display("[TB] FAIL auto_ts: got %0d expected %0d", ts_value_a, TS); end
        checks++;
        if ({id_ok_a, ts_ok_a, match_a, timeout_a} !== 4'b1110) begin
            failures++; $display("[TB] FAIL auto_flags: got %b expected 1110", {id_ok_a, ts_ok_a, match_a, timeout_a});
        end
        @(posedge clock); #1;
        checks++;
        if ({done_a, busy_a, match_a} !== 3'b001) begin
            failures++; $display("[TB] FAIL auto_pulse: got %b expected 001", {done_a, busy_a, match_a});
        end
    endtask

    task automatic test_wait_states;
        int n, idc, tsc;
        logic [31:0] mid;
        wait_per_read_a = 3;
        run_a(0, n, idc, tsc, mid);
        wait_per_read_a = 0;
        checks++;
        if (n !== 11) begin failures++; $display("[TB] FAIL wait_latency: got %0d expected 11", n); end
        checks++;
        if (idc !== 4) begin failures++; $display("[TB] FAIL wait_id_read_cycles: got %0d expected 4", idc); end
        checks++;
        if (tsc !== 4) begin failures++; $display("[TB] FAIL wait_ts_read_cycles: got %0d expected 4", tsc); end
        checks++;
        if ({match_a, ts_value_a} !== {1'b1, TS}) begin
            failures++; $display("[TB] FAIL wait_result: got %b/%0d expected 1/%0d", match_a, ts_value_a, TS);
        end
    endtask

    task automatic test_bad_timestamp;
        int n, idc, tsc;
        logic [31:0] mid;
        ts_word_a = 32'h12345678;
        run_a(0, n, idc, tsc, mid);
        ts_word_a = TS;
        checks++;
        if ({n, idc, tsc} !== {32'd5, 32'd1, 32'd1}) begin
            failures++; $display("[TB] FAIL bad_ts_timing: got %0d/%0d/%0d expected 5/1/1", n, idc, tsc);
        end
        checks++;
        if (mid !== TS) begin failures++; $display("[TB] FAIL bad_ts_hold: got %0h expected %0h", mid, TS); end
        checks++;
        if ({id_ok_a, ts_ok_a, match_a, timeout_a} !== 4'b1000) begin
            failures++; $display("[TB] FAIL bad_ts_flags: got %b expected 1000", {id_ok_a, ts_ok_a, match_a, timeout_a});
        end
        checks++;
        if (ts_value_a !== 32'h12345678) begin failures++; $display("[TB] FAIL bad_ts_value: got %0h expected 12345678", ts_value_a); end
        checks++;
        if (id_value_a !== 32'd0) begin failures++; $display("[TB] FAIL bad_ts_id: got %0h expected 0", id_value_a); end
    endtask

    task automatic test_latency;
        int n, rd;
        checks++;
        if ({match_c, busy_c, id_value_c} !== 34'd0) begin
            failures++; $display("[TB] FAIL lat_no_autostart: got %b/%0h expected 0/0", match_c, id_value_c);
        end
        @(posedge clock); #1 start_c = 1'b1;
        n = 0; rd = 0;
        do begin
            @(posedge clock); #1 start_c = 1'b0; n++;
            if (ifc.avm_read) rd++;
        end while (!done_c && n < 300);
        checks++;
        if (n !== 9) begin failures++; $display("[TB] FAIL lat_latency: got %0d expected 9", n); end
        checks++;
        if (rd !== 2) begin failures++; $display("[TB] FAIL lat_read_cycles: got %0d expected 2", rd); end
        checks++;
        if (id_value_c !== ID_C) begin failures++; $display("[TB] FAIL lat_id: got %0h expected %0h", id_value_c, ID_C); end
        checks++;
        if (ts_value_c !== TS) begin failures++; $display("[TB] FAIL lat_ts: got %0h expected %0h", ts_value_c, TS); end
        checks++;
        if ({id_ok_c, ts_ok_c, match_c} !== 3'b111) begin
            failures++; $display("[TB] FAIL lat_flags: got %b expected 111", {id_ok_c, ts_ok_c, match_c});
        end
    endtask

    task automatic test_recheck;
        int n, pulses;
        wait_done_b(n);
        checks++;
        if (n >= 300) begin failures++; $display("[TB] FAIL recheck_sync: got %0d cycles expected under 300", n); end
        wait_done_b(n);
        checks++;
        if (n !== 105) begin failures++; $display("[TB] FAIL recheck_period: got %0d expected 105", n); end
        repeat (100) @(posedge clock);
        #1 start_b = 1'b1;
        n = 0;
        do begin
            @(posedge clock); #1 start_b = 1'b0; n++;
        end while (!done_b && n < 300);
        checks++;
        if (n !== 5) begin failures++; $display("[TB] FAIL recheck_coincide_latency: got %0d expected 5", n); end
        pulses = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clock); #1 if (done_b) pulses++;
        end
        checks++;
        if (pulses !== 0) begin failures++; $display("[TB] FAIL recheck_single_run: got %0d extra done expected 0", pulses); end
    endtask

    task automatic test_timeout;
        int n, rd;
        stuck_b = 1'b1;
        run_b(n, rd);
        stuck_b = 1'b0;
        checks++;
        if (n !== 19) begin failures++; $display("[TB] FAIL timeout_latency: got %0d expected 19", n); end
        checks++;
        if (rd !== 16) begin failures++; $display("[TB] FAIL timeout_read_cycles: got %0d expected 16", rd); end
        checks++;
        if ({id_ok_b, ts_ok_b, match_b, timeout_b} !== 4'b0001) begin
            failures++; $display("[TB] FAIL timeout_flags: got %b expected 0001", {id_ok_b, ts_ok_b, match_b, timeout_b});
        end
        checks++;
        if ({id_value_b, ts_value_b} !== {32'd0, TS}) begin
            failures++; $display("[TB] FAIL timeout_values_kept: got %0h/%0h expected 0/%0h", id_value_b, ts_value_b, TS);
        end
        run_b(n, rd);
        checks++;
        if (n !== 5) begin failures++; $display("[TB] FAIL timeout_recover_latency: got %0d expected 5", n); end
        checks++;
        if ({id_ok_b, ts_ok_b, match_b, timeout_b} !== 4'b1110) begin
            failures++; $display("[TB] FAIL timeout_recover_flags: got %b expected 1110", {id_ok_b, ts_ok_b, match_b, timeout_b});
        end
    endtask

    task automatic test_busy_start;
        int n, idc, tsc, pulses;
        logic [31:0] mid;
        run_a(2, n, idc, tsc, mid);
        checks++;
        if (n !== 5) begin failures++; $display("[TB] FAIL busy_first_run: got %0d expected 5", n); end
        count_done_a(20, pulses);
        checks++;
        if (pulses !== 0) begin failures++; $display("[TB] FAIL busy_start_dropped: got %0d runs expected 0", pulses); end
        run_a(0, n, idc, tsc, mid);
        checks++;
        if ({n, match_a} !== {32'd5, 1'b1}) begin
            failures++; $display("[TB] FAIL idle_start_run: got %0d/%b expected 5/1", n, match_a);
        end
    endtask

    task automatic test_reset_mid_read;
        int n;
        @(posedge clock); #1 start_a = 1'b1;
        @(posedge clock); #1 start_a = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        checks++;
        if ({ifa.avm_read, ifa.avm_address} !== 2'b11) begin
            failures++; $display("[TB] FAIL midread_req_ts: got %b expected 11", {ifa.avm_read, ifa.avm_address});
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({busy_a, done_a, id_ok_a, ts_ok_a, match_a, timeout_a, ifa.avm_read, ifa.avm_address,
             id_value_a, ts_value_a} !== 72'd0) begin
            failures++; $display("[TB] FAIL midread_async_clear: outputs not all zero, read=%b busy=%b", ifa.avm_read, busy_a);
        end
        @(negedge clock) reset_n = 1'b1;
        n = 0;
        do begin
            @(posedge clock); #1 n++;
        end while (!done_a && n < 300);
        checks++;
        if (n !== 5) begin failures++; $display("[TB] FAIL midread_restart_latency: got %0d expected 5", n); end
        checks++;
        if ({match_a, ts_value_a} !== {1'b1, TS}) begin
            failures++; $display("[TB] FAIL midread_restart_result: got %b/%0h expected 1/%0h", match_a, ts_value_a, TS);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_auto_start();
        test_wait_states();
        test_bad_timestamp();
        test_latency();
        test_recheck();
        test_timeout();
        test_busy_start();
        test_reset_mid_read();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
